// File: rtl/key_filter_if.sv
// Key filter signal bundle: raw active-low key in, debounced level and edge strobes out.
interface key_filter_if;
  logic pi_key;
  logic po_key_level;
  logic po_press_flag;
  logic po_release_flag;

  modport master (output pi_key, input po_key_level, po_press_flag, po_release_flag);
  modport slave  (input pi_key, output po_key_level, po_press_flag, po_release_flag);
endinterface

// File: rtl/key_filter.sv
// Push-button debouncer: two-flop synchroniser feeding a stable-count FSM that
// emits a registered active-high level plus one-cycle press/release strobes.
module key_filter #(
  parameter int CNT_MAX = 999_999
) (
  input logic        clk,
  input logic        rst,
  key_filter_if.slave kif
);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  typedef enum logic [1:0] {IDLE, PRESS_FILT, PRESSED, REL_FILT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s1;
  logic             key_s;
  logic             key_level;
  logic             press_flag;
  logic             release_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1           <= 1'b1;
      key_s        <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      key_level    <= 1'b0;
      press_flag   <= 1'b0;
      release_flag <= 1'b0;
    end else begin
      s1           <= kif.pi_key;
      key_s        <= s1;
      press_flag   <= 1'b0;
      release_flag <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!key_s) state <= PRESS_FILT;
        end
        PRESS_FILT: begin
          if (key_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= PRESSED;
            key_level  <= 1'b1;
            press_flag <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          cnt <= '0;
          if (key_s) state <= REL_FILT;
        end
        REL_FILT: begin
          // A low sample here is contact bounce: stay pressed, no strobe.
          if (!key_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state        <= IDLE;
            key_level    <= 1'b0;
            release_flag <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign kif.po_key_level    = key_level;
  assign kif.po_press_flag   = press_flag;
  assign kif.po_release_flag = release_flag;
endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter: expected strobes (kind and edge number) are queued
// as stimulus is driven and matched by a monitor when the DUT pulses a flag.
module tb_key_filter;
  localparam int CNT_MAX = 9;
  localparam int LAT     = CNT_MAX + 4;
  localparam int K_PRESS = 1;
  localparam int K_REL   = 2;

  typedef struct {
    int kind;
    int edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  key_filter_if kif();

  key_filter #(.CNT_MAX(CNT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_exp(input int kind);
    exp_t e;
    e.kind    = kind;
    e.edge_no = edge_cnt + LAT;
    q.push_back(e);
  endtask

  // Strobe monitor: every flag pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (kif.po_press_flag && kif.po_release_flag)
        chk("flags_exclusive", 32'd1, 32'd0);
      else if (kif.po_press_flag || kif.po_release_flag) begin
        if (q.size() == 0) begin
          chk("unexpected_flag", kif.po_press_flag ? K_PRESS : K_REL, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("flag_kind", kif.po_press_flag ? K_PRESS : K_REL, e.kind);
          chk("flag_edge", edge_cnt, e.edge_no);
          chk("flag_level", kif.po_key_level, kif.po_press_flag ? 1 : 0);
        end
      end
    end
  end

  initial begin
    kif.pi_key = 1'b1;
    rst = 1'b1;

    // reset then idle
    wait_cycles(3);
    chk("rst_level",   kif.po_key_level,    0);
    chk("rst_press",   kif.po_press_flag,   0);
    chk("rst_release", kif.po_release_flag, 0);
    rst = 1'b0;
    wait_cycles(100);
    chk("idle_level", kif.po_key_level, 0);
    chk("idle_queue", q.size(), 0);

    // clean press
    kif.pi_key = 1'b0;
    push_exp(K_PRESS);
    wait_cycles(LAT - 1);
    chk("press_level_before", kif.po_key_level, 0);
    wait_cycles(1);
    chk("press_level_after", kif.po_key_level, 1);
    wait_cycles(17);
    chk("press_queue", q.size(), 0);
    chk("press_level_hold", kif.po_key_level, 1);

    // clean release
    kif.pi_key = 1'b1;
    push_exp(K_REL);
    wait_cycles(LAT - 1);
    chk("rel_level_before", kif.po_key_level, 1);
    wait_cycles(1);
    chk("rel_level_after", kif.po_key_level, 0);
    wait_cycles(10);
    chk("rel_queue", q.size(), 0);

    // bouncy press: five toggles three cycles apart, last one holds low
    kif.pi_key = 1'b0; wait_cycles(3);
    kif.pi_key = 1'b1; wait_cycles(3);
    kif.pi_key = 1'b0; wait_cycles(3);
    kif.pi_key = 1'b1; wait_cycles(3);
    kif.pi_key = 1'b0;
    push_exp(K_PRESS);
    wait_cycles(LAT - 1);
    chk("bounce_level_before", kif.po_key_level, 0);
    wait_cycles(8);
    chk("bounce_level_after", kif.po_key_level, 1);
    chk("bounce_queue", q.size(), 0);

    // release bounce: short high then low again, stays pressed
    kif.pi_key = 1'b1; wait_cycles(5);
    kif.pi_key = 1'b0; wait_cycles(20);
    chk("relbounce_level", kif.po_key_level, 1);
    chk("relbounce_queue", q.size(), 0);

    // release after bounce returns to idle with normal latency
    kif.pi_key = 1'b1;
    push_exp(K_REL);
    wait_cycles(LAT - 1);
    chk("rel2_level_before", kif.po_key_level, 1);
    wait_cycles(1);
    chk("rel2_level_after", kif.po_key_level, 0);
    wait_cycles(5);
    chk("rel2_queue", q.size(), 0);

    // async reset while counting in PRESS_FILT (cnt=5)
    kif.pi_key = 1'b0;
    wait_cycles(8);
    #2 rst = 1'b1;
    #1;
    chk("midrst_level",   kif.po_key_level,    0);
    chk("midrst_press",   kif.po_press_flag,   0);
    chk("midrst_release", kif.po_release_flag, 0);
    wait_cycles(2);
    rst = 1'b0;
    push_exp(K_PRESS);
    wait_cycles(LAT - 1);
    chk("midrst_level_before", kif.po_key_level, 0);
    wait_cycles(1);
    chk("midrst_level_after", kif.po_key_level, 1);
    wait_cycles(3);
    chk("midrst_queue", q.size(), 0);

    // async reset while pressed clears the level between edges
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("prst_level", kif.po_key_level, 0);
    chk("prst_press", kif.po_press_flag, 0);
    kif.pi_key = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(20);
    chk("prst_idle_level", kif.po_key_level, 0);
    chk("final_queue", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
